debounce_sync: RTL and testbench
================================

Name: debounce_sync

Overview:
- Conditions a raw asynchronous level input (push-button, switch, external strobe) before it reaches the D input of the flip-flop stages downstream.
- Synchronises the input into the clk domain through a flop chain.
- Qualifies it with a stability counter and publishes a clean registered level, plus single-cycle rise/fall pulses.
- Sits directly upstream of the flip-flop/register blocks and feeds their data input.

Parameters:
- SYNC_STAGES, 2, number of synchroniser flops; legal range 2..4.
- CNT_MAX, 1000, consecutive stable cycles required before dout changes; must be >= 1.
- CNT_WIDTH, 10, counter width; must satisfy 2^CNT_WIDTH > CNT_MAX-1.
- RST_VAL, 0, reset value of the synchroniser chain and dout.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- rst  input  1  asynchronous reset, active-high.
- din  input  1  raw asynchronous level to be conditioned.
- dout  output  1  debounced, synchronised level (registered).
- rise  output  1  one-cycle pulse when dout goes 0->1 (registered).
- fall  output  1  one-cycle pulse when dout goes 1->0 (registered).
- busy  output  1  high while a candidate transition is being qualified.

Behaviour:
- Reset:
  - rst high asynchronously forces all sync flops = RST_VAL, dout = RST_VAL, cnt = 0, rise = 0, fall = 0, busy = 0.
  - FSM goes to STABLE_LO if RST_VAL = 0, else STABLE_HI.
  - Outputs hold these values for as long as rst is high.
  - Reset mid-qualification discards the count; no pulse is emitted.
- Synchroniser:
  - sync[0] <= din; sync[i] <= sync[i-1].
  - s = sync[SYNC_STAGES-1].
  - No logic on din before sync[0].
- FSM states: STABLE_LO, WAIT_HI, STABLE_HI, WAIT_LO.
  - STABLE_LO: s = 1 -> WAIT_HI, cnt <= 1.
  - WAIT_HI:
    - s = 0 -> STABLE_LO, cnt <= 0 (glitch rejected).
    - else if cnt == CNT_MAX-1 -> STABLE_HI, dout <= 1, rise <= 1, cnt <= 0.
    - else cnt <= cnt+1.
  - STABLE_HI, WAIT_LO: mirror of the above with polarity inverted; fall is pulsed instead of rise.
  - CNT_MAX = 1: the transition completes on the first edge at which s differs. The FSM passes straight from STABLE_* to the opposite STABLE_* in one edge, with the pulse asserted.
- Latency:
  - Let T1 be the first edge sampling the new din level, with din held stable.
  - dout changes at edge T1 + SYNC_STAGES - 1 + CNT_MAX.
  - rise/fall are high for exactly the one cycle following that edge.
- Glitch rule: any return of s to the current dout level before qualification completes resets the count to 0. Every qualification requires CNT_MAX fresh consecutive cycles.
- busy = 1 exactly in WAIT_HI/WAIT_LO; registered as a state decode.
- rise and fall are never high simultaneously.
- Back-to-back pulses are separated by at least CNT_MAX cycles.
- The counter never wraps; it is bounded by CNT_MAX-1.

Test Plan:
All scenarios use SYNC_STAGES=2, CNT_MAX=4, RST_VAL=0, clk period 20.
1. Reset: rst=1 with din toggling randomly -> dout=0, rise=0, fall=0, busy=0 throughout. Repeat with rst asserted between clock edges -> outputs clear immediately, without waiting for an edge.
2. Clean rise: rst released; din 0->1 sampled first at edge 1 and held -> busy=1 from edge 3. dout=1 and rise=1 after edge 6; rise=0 after edge 7; busy=0 after edge 6.
3. Glitch reject: din high for exactly 3 edges, then low -> dout stays 0; rise never asserts; busy returns to 0 with the count cleared.
4. Clean fall: from dout=1, din 1->0 held -> dout=0 and fall=1 for one cycle, 5 edges after the first sampled low edge; rise stays 0.
5. Reset mid-qualification: rst asserted while busy=1 with cnt=2 -> immediate dout=0, busy=0, no pulse. After release, a held din=1 requires the full 5-edge latency again.
6. Bounce train: din toggles every cycle for 20 cycles, then settles high -> exactly one rise pulse, zero fall pulses, final dout=1.

Source files
------------

// File: rtl/debounce_sync.sv
// Synchronises a raw asynchronous level into clk, qualifies it with a stability
// counter and publishes a clean level plus single-cycle rise/fall pulses.
module debounce_sync #(
    parameter int   SYNC_STAGES = 2,
    parameter int   CNT_MAX     = 1000,
    parameter int   CNT_WIDTH   = 10,
    parameter logic RST_VAL     = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout,
    output logic rise,
    output logic fall,
    output logic busy
);

    typedef enum logic [1:0] {STABLE_LO, WAIT_HI, STABLE_HI, WAIT_LO} state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(CNT_MAX - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

    logic [SYNC_STAGES-1:0] sync;
    logic                   s;
    state_t                 state;
    logic [CNT_WIDTH-1:0]   cnt;

    // Synchroniser stage boundary: din lands directly on sync[0]
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync <= {SYNC_STAGES{RST_VAL}};
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], din};
        end
    end

    assign s = sync[SYNC_STAGES-1];

    // Qualification stage boundary: every output is registered alongside the state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RST_VAL ? STABLE_HI : STABLE_LO;
            cnt   <= '0;
            dout  <= RST_VAL;
            rise  <= 1'b0;
            fall  <= 1'b0;
            busy  <= 1'b0;
        end else begin
            rise <= 1'b0;
            fall <= 1'b0;
            case (state)
                STABLE_LO: begin
                    if (s) begin
                        if (CNT_MAX == 1) begin
                            state <= STABLE_HI;
                            dout  <= 1'b1;
                            rise  <= 1'b1;
                            cnt   <= '0;
                            busy  <= 1'b0;
                        end else begin
                            state <= WAIT_HI;
                            cnt   <= CNT_ONE;
                            busy  <= 1'b1;
                        end
                    end
                end
                WAIT_HI: begin
                    if (!s) begin
                        state <= STABLE_LO;
                        cnt   <= '0;
                        busy  <= 1'b0;
                    end else if (cnt == CNT_LAST) begin
                        state <= STABLE_HI;
                        dout  <= 1'b1;
                        rise  <= 1'b1;
                        cnt   <= '0;
                        busy  <= 1'b0;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                STABLE_HI: begin
                    if (!s) begin
                        if (CNT_MAX == 1) begin
                            state <= STABLE_LO;
                            dout  <= 1'b0;
                            fall  <= 1'b1;
                            cnt   <= '0;
                            busy  <= 1'b0;
                        end else begin
                            state <= WAIT_LO;
                            cnt   <= CNT_ONE;
                            busy  <= 1'b1;
                        end
                    end
                end
                WAIT_LO: begin
                    if (s) begin
                        state <= STABLE_HI;
                        cnt   <= '0;
                        busy  <= 1'b0;
                    end else if (cnt == CNT_LAST) begin
                        state <= STABLE_LO;
                        dout  <= 1'b0;
                        fall  <= 1'b1;
                        cnt   <= '0;
                        busy  <= 1'b0;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                default: begin
                    state <= STABLE_LO;
                    cnt   <= '0;
                    dout  <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_debounce_sync.sv
// Scoreboard bench for debounce_sync: a run-length model predicts each cycle's
// {dout,rise,fall,busy}; scenario tasks pop and compare after every edge.
module tb_debounce_sync;

    localparam int SYNC_STAGES = 2;
    localparam int CNT_MAX     = 4;
    localparam int CNT_WIDTH   = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic din = 1'b0;
    logic dout, rise, fall, busy;

    int checks   = 0;
    int failures = 0;
    int rise_cnt = 0;
    int fall_cnt = 0;

    logic [3:0] sb[$];
    logic [3:0] exp_v, got_v;

    logic [1:0] m_sync  = 2'b00;
    logic       m_dout  = 1'b0;
    int         runlen  = 0;

    debounce_sync #(
        .SYNC_STAGES(SYNC_STAGES),
        .CNT_MAX    (CNT_MAX),
        .CNT_WIDTH  (CNT_WIDTH),
        .RST_VAL    (1'b0)
    ) dut (
        .clk (clk),
        .rst (rst),
        .din (din),
        .dout(dout),
        .rise(rise),
        .fall(fall),
        .busy(busy)
    );

    always #10 clk = ~clk;

    // Drive din for one edge, advance the model, push its prediction, settle.
    task automatic step(input logic d);
        logic s_old, r, f;
        r = 1'b0;
        f = 1'b0;
        din = d;
        @(posedge clk);
        if (rst) begin
            m_sync = 2'b00;
            m_dout = 1'b0;
            runlen = 0;
        end else begin
            s_old  = m_sync[1];
            m_sync = {m_sync[0], d};
            if (s_old != m_dout) begin
                runlen++;
                if (runlen == CNT_MAX) begin
                    m_dout = s_old;
                    r      = s_old;
                    f      = !s_old;
                    runlen = 0;
                end
            end else begin
                runlen = 0;
            end
        end
        sb.push_back({m_dout, r, f, (runlen != 0)});
        #1;
        if (rise) rise_cnt++;
        if (fall) fall_cnt++;
    endtask

    task automatic test_reset();
        for (int k = 1; k <= 6; k++) begin
            step(1'($urandom_range(0, 1)));
            exp_v = sb.pop_front();
            got_v = {dout, rise, fall, busy};
            checks++;
            if (got_v !== exp_v) begin
                failures++;
                $display("FAIL reset_hold step %0d: got %b expected %b", k, got_v, exp_v);
            end
        end
        rst = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            step(k > 2);
            exp_v = sb.pop_front();
            got_v = {dout, rise, fall, busy};
            checks++;
            if (got_v !== exp_v) begin
                failures++;
                $display("FAIL reset_prep step %0d: got %b expected %b", k, got_v, exp_v);
            end
        end
        // Assert reset between edges: outputs must clear without a clock edge
        #4 rst = 1'b1;
        #1;
        checks++;
        if ({dout, rise, fall, busy} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_async: got %b expected 0000", {dout, rise, fall, busy});
        end
        for (int k = 1; k <= 3; k++) begin
            step(1'($urandom_range(0, 1)));
            exp_v = sb.pop_front();
            got_v = {dout, rise, fall, busy};
            checks++;
            if (got_v !== exp_v) begin
                failures++;
                $display("FAIL reset_async_hold step %0d: got %b expected %b", k, got_v, exp_v);
            end
        end
        rst = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            step(1'b0);
            exp_v = sb.pop_front();
            got_v = {dout, rise, fall, busy};
            checks++;
            if (got_v !== exp_v) begin
                failures++;
                $display("FAIL reset_settle step %0d: got %b expected %b", k, got_v, exp_v);
            end
        end
    endtask

    task automatic test_clean_rise();
        rise_cnt = 0;
        for (int k = 1; k <= 10; k++) begin
            step(1'b1);
            exp_v = sb.pop_front();
            got_v = {dout, rise, fall, busy};
            checks++;
            if (got_v !== exp_v) begin
                failures++;
                $display("FAIL clean_rise step %0d: got %b expected %b", k, got_v, exp_v);
            end
            if (k == 3) begin
                checks++;
                if (busy !== 1'b1) begin
                    failures++;
                    $display("FAIL clean_rise_busy_edge3: got %b expected 1", busy);
                end
            end
            if (k == 6) begin
                checks++;
                if ({dout, rise, busy} !== 3'b110) begin
                    failures++;
                    $display("FAIL clean_rise_edge6: got %b expected 110", {dout, rise, busy});
                end
            end
        end
        checks++;
        if (rise_cnt !== 1) begin
            failures++;
            $display("FAIL clean_rise_count: got %0d expected 1", rise_cnt);
        end
    endtask

    task automatic test_clean_fall();
        rise_cnt = 0;
        fall_cnt = 0;
        for (int k = 1; k <= 10; k++) begin
            step(1'b0);
            exp_v = sb.pop_front();
            got_v = {dout, rise, fall, busy};
            checks++;
            if (got_v !== exp_v) begin
                failures++;
                $display("FAIL clean_fall step %0d: got %b expected %b", k, got_v, exp_v);
            end
            if (k == 6) begin
                checks++;
                if ({dout, fall} !== 2'b01) begin
                    failures++;
                    $display("FAIL clean_fall_edge6: got %b expected 01", {dout, fall});
                end
            end
        end
        checks++;
        if (fall_cnt !== 1 || rise_cnt !== 0) begin
            failures++;
            $display("FAIL clean_fall_count: got fall=%0d rise=%0d expected fall=1 rise=0", fall_cnt, rise_cnt);
        end
    endtask

    task automatic test_glitch();
        rise_cnt = 0;
        for (int k = 1; k <= 10; k++) begin
            step(k <= 3);
            exp_v = sb.pop_front();
            got_v = {dout, rise, fall, busy};
            checks++;
            if (got_v !== exp_v) begin
                failures++;
                $display("FAIL glitch step %0d: got %b expected %b", k, got_v, exp_v);
            end
        end
        checks++;
        if (rise_cnt !== 0 || {dout, busy} !== 2'b00) begin
            failures++;
            $display("FAIL glitch_final: got rise_cnt=%0d dout/busy=%b expected 0 00", rise_cnt, {dout, busy});
        end
    endtask

    task automatic test_reset_mid_qual();
        rise_cnt = 0;
        for (int k = 1; k <= 4; k++) begin
            step(1'b1);
            exp_v = sb.pop_front();
            got_v = {dout, rise, fall, busy};
            checks++;
            if (got_v !== exp_v) begin
                failures++;
                $display("FAIL midrst_pre step %0d: got %b expected %b", k, got_v, exp_v);
            end
        end
        #4 rst = 1'b1;
        #1;
        checks++;
        if ({dout, rise, fall, busy} !== 4'b0000) begin
            failures++;
            $display("FAIL midrst_async: got %b expected 0000", {dout, rise, fall, busy});
        end
        step(1'b1);
        exp_v = sb.pop_front();
        got_v = {dout, rise, fall, busy};
        checks++;
        if (got_v !== exp_v) begin
            failures++;
            $display("FAIL midrst_hold: got %b expected %b", got_v, exp_v);
        end
        rst = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            step(1'b1);
            exp_v = sb.pop_front();
            got_v = {dout, rise, fall, busy};
            checks++;
            if (got_v !== exp_v) begin
                failures++;
                $display("FAIL midrst_requal step %0d: got %b expected %b", k, got_v, exp_v);
            end
            if (k == 5 || k == 6) begin
                checks++;
                if (dout !== (k == 6)) begin
                    failures++;
                    $display("FAIL midrst_latency edge %0d: got dout=%b expected %b", k, dout, (k == 6));
                end
            end
        end
        checks++;
        if (rise_cnt !== 1) begin
            failures++;
            $display("FAIL midrst_rise_count: got %0d expected 1", rise_cnt);
        end
    endtask

    task automatic test_bounce();
        for (int k = 1; k <= 8; k++) begin
            step(1'b0);
            exp_v = sb.pop_front();
            got_v = {dout, rise, fall, busy};
            checks++;
            if (got_v !== exp_v) begin
                failures++;
                $display("FAIL bounce_prep step %0d: got %b expected %b", k, got_v, exp_v);
            end
        end
        rise_cnt = 0;
        fall_cnt = 0;
        for (int k = 1; k <= 34; k++) begin
            step((k > 20) ? 1'b1 : 1'(k % 2));
            exp_v = sb.pop_front();
            got_v = {dout, rise, fall, busy};
            checks++;
            if (got_v !== exp_v) begin
                failures++;
                $display("FAIL bounce step %0d: got %b expected %b", k, got_v, exp_v);
            end
            checks++;
            if (rise && fall) begin
                failures++;
                $display("FAIL bounce_exclusive step %0d: got rise=1 fall=1 expected not both", k);
            end
        end
        checks++;
        if (rise_cnt !== 1 || fall_cnt !== 0 || dout !== 1'b1) begin
            failures++;
            $display("FAIL bounce_final: got rise=%0d fall=%0d dout=%b expected 1 0 1", rise_cnt, fall_cnt, dout);
        end
    endtask

    initial begin
        test_reset();
        test_clean_rise();
        test_clean_fall();
        test_glitch();
        test_reset_mid_qual();
        test_bounce();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
